t05_serial_rx_fifo: RTL and testbench
=====================================

Name: t05_serial_rx_fifo

Overview:
Parametrised successor to the fixed 8-bit, 3-clocks-per-bit serial input path of the t05 top level.
- Deserialises a bit stream on miso into DATA_W-bit words.
- Bit period, word width, bit order and burst length are configurable.
- Completed words are buffered in a first-word-fall-through FIFO for the downstream consumer (histogram/encoder stage).
- Sits between the pad-level serial input and the t05 datapath, under control of the top-level FSM.

Parameters:
DATA_W, 8, bits per word
CLKS_PER_BIT, 3, hwclk cycles per serial bit (>=2); HALF = CLKS_PER_BIT/2 (integer divide)
DEPTH, 4, FIFO entries (power of 2, >=2)
FRAME_W, 8, width of frame-count input

Ports:
hwclk  input  1  system clock, rising-edge
nrst  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begin burst (ignored while busy)
stop  input  1  abort burst; partial word discarded
lsb_first  input  1  0: first bit is MSB; 1: first bit is LSB; latched at start
frames  input  FRAME_W  words per burst, latched at start; 0 = continuous until stop
miso  input  1  serial data in
rd_en  input  1  pop request
rd_data  output  DATA_W  FIFO head word, valid when rd_valid
rd_valid  output  1  FIFO not empty
count  output  $clog2(DEPTH)+1  FIFO occupancy
busy  output  1  burst in progress
frame_done  output  1  one-cycle pulse per completed word
overflow  output  1  sticky; word dropped because FIFO full
parity_err  output  1  sticky; see Optional Feature

Behaviour:
Interface:
- One clock, hwclk.
- nrst is synchronous and active-low.

Reset (nrst=0 at a rising edge):
- FSM goes to IDLE; FIFO is emptied.
- rd_valid=0, count=0, busy=0, frame_done=0, overflow=0, parity_err=0, rd_data=0.
- Reset mid-burst or mid-word discards all partial and buffered data.

FSM states:
- IDLE
  - busy=0.
  - start=1 → SHIFT. At the same edge: latch lsb_first and frames; clear overflow and parity_err; tick=0, bit=0.
- SHIFT
  - busy=1. tick counts 0..CLKS_PER_BIT-1 and wraps.
  - At the edge where tick==HALF, miso is sampled into the shift register. MSB-first shifts left; LSB-first shifts right.
  - Bit k of word n is sampled at edge (start edge) + 1 + (n*DATA_W + k)*CLKS_PER_BIT + HALF.
  - On the edge sampling the last bit of a word:
    - The assembled word (including that bit) is written to the FIFO.
    - frame_done pulses the following cycle.
    - rd_valid is high from the following cycle if the FIFO was empty.
  - Words are back-to-back: the next word's bit 0 period starts at the tick wrap with no gap.
  - After the last word of a finite burst → FINISH.
- FINISH
  - Waits out the remaining ticks of the final bit period, then → IDLE.
  - busy falls on the same edge that enters IDLE.
- Abort
  - stop=1 in SHIFT or FINISH → IDLE on the next edge.
  - The partial word is dropped; the FIFO contents are kept.
  - stop has priority over a same-cycle word completion: that word is not written.

FIFO:
- First-word-fall-through: rd_data shows the head word whenever rd_valid=1.
- Pop happens on rd_en && rd_valid. rd_en while empty is ignored.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Push while full with no same-cycle pop: word dropped, overflow set, count unchanged.
- Push while full with a same-cycle pop: both accepted, count stays DEPTH, no overflow.
- Push and pop on an empty FIFO: push only (the pop sees rd_valid=0).

Optional Feature:
Macro T05_SERIAL_RX_PARITY_EN.
- Defined:
  - Each word carries one extra even-parity bit after its DATA_W data bits. Frame length is DATA_W+1 bit periods.
  - On parity mismatch: the word is not written and parity_err (sticky) is set. frame_done still pulses and the frame counter still decrements.
- Not defined:
  - No parity bit; frame length is DATA_W bit periods.
  - parity_err is tied to 0 (the port is always present).

Test Plan:
1. Defaults, lsb_first=0, frames=1; start, then miso bits 0,1,0,0,0,0,0,1 at 3 clocks/bit → rd_data=0x41, rd_valid=1, count=1; busy low 24 cycles after the start edge + 1.
2. Same stream with lsb_first=1 → rd_data=0x82. Then frames=3 sending 0x41,0x42,0x43 back-to-back → 3 frame_done pulses; pops return 0x41,0x42,0x43 in order.
3. frames=6, DEPTH=4, rd_en=0 → count saturates at 4, overflow=1, FIFO holds the first 4 words. Next start clears overflow.
4. FIFO full with rd_en=1 on the cycle the 5th word completes → no overflow, count stays 4, head advances to word 2.
5. frames=0 continuous; assert stop mid-word 3 → busy=0 next cycle, count=2, partial word absent. Separately, nrst=0 mid-word → count=0, rd_valid=0.
6. With T05_SERIAL_RX_PARITY_EN: 0x41 with parity bit 0 → stored. 0x41 with parity bit 1 → not stored, parity_err=1, frame_done still pulses.

Source files
------------

// File: rtl/t05_serial_rx_fifo.sv
// t05 serial receive path: deserialises miso into DATA_W-bit words and buffers them in an FWFT FIFO.
// Define T05_SERIAL_RX_PARITY_EN to append and check one even-parity bit per word.
module t05_serial_rx_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 3,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FRAME_W      = 8
) (
  input  logic                   hwclk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   lsb_first,
  input  logic [FRAME_W-1:0]     frames,
  input  logic                   miso,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   parity_err
);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
`ifdef T05_SERIAL_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_W + 1;
`else
  localparam int unsigned FRAME_BITS = DATA_W;
`endif
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [DATA_W-1:0]  sr_q, sr_d, sr_shift, wdata;
  logic               lsb_q, lsb_d, cont_q, cont_d;
  logic [FRAME_W-1:0] remain_q, remain_d;
  logic               busy_q, busy_d, fdone_q, fdone_d, ovf_q, ovf_d;
  logic               clr_flags, push, sample, wrap, last_bit;
`ifdef T05_SERIAL_RX_PARITY_EN
  logic               perr_q, perr_d, perr_set;
`endif

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rv_q, rv_d, pop, full, push_ok;

  assign sample   = (tick_q == TW'(HALF));
  assign wrap     = (tick_q == TW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_q == BW'(FRAME_BITS - 1));
  assign sr_shift = lsb_q ? {miso, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], miso};

  // Burst sequencing, bit timing and word assembly
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    lsb_d     = lsb_q;
    cont_d    = cont_q;
    remain_d  = remain_q;
    fdone_d   = 1'b0;
    clr_flags = 1'b0;
    push      = 1'b0;
    wdata     = sr_shift;
`ifdef T05_SERIAL_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          lsb_d     = lsb_first;
          remain_d  = frames;
          cont_d    = (frames == '0);
          tick_d    = '0;
          bit_d     = '0;
          clr_flags = 1'b1;
        end
      end
      SHIFT: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          tick_d = wrap ? '0 : tick_q + TW'(1);
          if (wrap) bit_d = last_bit ? '0 : bit_q + BW'(1);
          if (sample) begin
`ifdef T05_SERIAL_RX_PARITY_EN
            if (bit_q < BW'(DATA_W)) sr_d = sr_shift;
`else
            sr_d = sr_shift;
`endif
            if (last_bit) begin
              fdone_d = 1'b1;
`ifdef T05_SERIAL_RX_PARITY_EN
              // Parity bit is the final sample; data already sits complete in sr_q
              wdata = sr_q;
              if ((^sr_q) == miso) push = 1'b1;
              else                 perr_set = 1'b1;
`else
              push = 1'b1;
`endif
              if (!cont_q) begin
                remain_d = remain_q - FRAME_W'(1);
                if (remain_q == FRAME_W'(1)) state_d = wrap ? IDLE : FINISH;
              end
            end
          end
        end
      end
      FINISH: begin
        if (stop || wrap) begin
          state_d = IDLE;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FWFT FIFO; a pop frees a slot for a same-cycle push when full
  always_comb begin
    pop      = rd_en && rv_q;
    full     = (cnt_q == CW'(DEPTH));
    push_ok  = push && (!full || pop);
    ovf_d    = clr_flags ? 1'b0 : (ovf_q || (push && full && !pop));
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      cnt_d           = cnt_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_d - CW'(1);
    end
    rv_d    = (cnt_d != '0);
    rdata_d = rv_d ? mem_d[rd_ptr_d] : '0;
`ifdef T05_SERIAL_RX_PARITY_EN
    perr_d  = clr_flags ? 1'b0 : (perr_q || perr_set);
`endif
  end

  always_ff @(posedge hwclk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      lsb_q    <= 1'b0;
      cont_q   <= 1'b0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
`ifdef T05_SERIAL_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      lsb_q    <= lsb_d;
      cont_q   <= cont_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
`ifdef T05_SERIAL_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  // Storage needs no reset: reads are gated by occupancy
  always_ff @(posedge hwclk) begin
    mem_q <= mem_d;
  end

  assign rd_data    = rdata_q;
  assign rd_valid   = rv_q;
  assign count      = cnt_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign overflow   = ovf_q;
`ifdef T05_SERIAL_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_t05_serial_rx_fifo.sv
// Directed bench for t05_serial_rx_fifo; covers the parity frame when T05_SERIAL_RX_PARITY_EN is defined.
module tb_t05_serial_rx_fifo;
  localparam int DATA_W  = 8;
  localparam int C       = 3;
  localparam int HALF    = C / 2;
  localparam int DEPTH   = 4;
  localparam int FRAME_W = 8;
`ifdef T05_SERIAL_RX_PARITY_EN
  localparam int FB = DATA_W + 1;
`else
  localparam int FB = DATA_W;
`endif

  logic                   hwclk = 1'b0;
  logic                   nrst = 1'b0, start = 1'b0, stop = 1'b0, lsb_first = 1'b0;
  logic                   miso = 1'b0, rd_en = 1'b0;
  logic [FRAME_W-1:0]     frames = '0;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid, busy, frame_done, overflow, parity_err;
  logic [$clog2(DEPTH):0] count;

  int vectors = 0;
  int miscompares = 0;
  int fd_cnt = 0;
  int fd_base = 0;

  t05_serial_rx_fifo #(
    .DATA_W(DATA_W), .CLKS_PER_BIT(C), .DEPTH(DEPTH), .FRAME_W(FRAME_W)
  ) dut (
    .hwclk(hwclk), .nrst(nrst), .start(start), .stop(stop), .lsb_first(lsb_first),
    .frames(frames), .miso(miso), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .busy(busy), .frame_done(frame_done), .overflow(overflow),
    .parity_err(parity_err)
  );

  always #5 hwclk = ~hwclk;

  always @(negedge hwclk) if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_burst(input logic [FRAME_W-1:0] n, input logic lsb);
    frames    = n;
    lsb_first = lsb;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Stream w MSB first; the final bit period is held for last_steps clocks
  task automatic send_word(input logic [7:0] w, input logic bad_par, input int last_steps);
    for (int k = 0; k < FB; k++) begin
      if (k < DATA_W) miso = w[DATA_W-1-k];
      else            miso = (^w) ^ bad_par;
      repeat ((k == FB - 1) ? last_steps : C) step();
    end
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_data", 32'(rd_data), 0);
    nrst = 1'b1;
    step();

    // Single MSB-first word and exact busy length
    begin_burst(8'd1, 1'b0);
    chk("t1_busy_start", 32'(busy), 1);
    send_word(8'h41, 1'b0, C - 1);
    chk("t1_busy_last", 32'(busy), 1);
    chk("t1_fdone", 32'(frame_done), 1);
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_count", 32'(count), 1);
    chk("t1_data", 32'(rd_data), 32'h41);
    step();
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_fdone_end", 32'(frame_done), 0);
    pop_one();
    chk("t1_empty_valid", 32'(rd_valid), 0);
    chk("t1_empty_count", 32'(count), 0);

    // Same stream received LSB first
    begin_burst(8'd1, 1'b1);
    send_word(8'h41, 1'b0, C);
    chk("t2_lsb_data", 32'(rd_data), 32'h82);
    chk("t2_lsb_busy", 32'(busy), 0);
    pop_one();

    // Three back-to-back words, popped in order
    fd_base = fd_cnt;
    begin_burst(8'd3, 1'b0);
    send_word(8'h41, 1'b0, C);
    send_word(8'h42, 1'b0, C);
    send_word(8'h43, 1'b0, C);
    chk("t2_fdone_pulses", 32'(fd_cnt - fd_base), 3);
    chk("t2_count", 32'(count), 3);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_pop0", 32'(rd_data), 32'h41);
    rd_en = 1'b1;
    step();
    chk("t2_pop1", 32'(rd_data), 32'h42);
    step();
    chk("t2_pop2", 32'(rd_data), 32'h43);
    step();
    rd_en = 1'b0;
    chk("t2_drained", 32'(rd_valid), 0);

    // Overflow: six words into a four-entry FIFO
    begin_burst(8'd6, 1'b0);
    for (int i = 0; i < 6; i++) send_word(8'(32'h10 + i), 1'b0, C);
    chk("t3_count_sat", 32'(count), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_head", 32'(rd_data), 32'h10);
    for (int i = 0; i < 4; i++) begin
      chk("t3_pop", 32'(rd_data), 32'(32'h10 + i));
      pop_one();
    end
    chk("t3_drained", 32'(count), 0);
    begin_burst(8'd1, 1'b0);
    chk("t3_ovf_cleared", 32'(overflow), 0);
    send_word(8'h55, 1'b0, C);
    chk("t3_new_word", 32'(rd_data), 32'h55);
    chk("t3_ovf_still0", 32'(overflow), 0);
    pop_one();

    // Full FIFO with a pop on the edge the fifth word lands
    begin_burst(8'd5, 1'b0);
    for (int i = 0; i < 4; i++) send_word(8'(32'h20 + i), 1'b0, C);
    chk("t4_full", 32'(count), 4);
    send_word(8'h24, 1'b0, HALF);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t4_count", 32'(count), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(rd_data), 32'h21);
    chk("t4_fdone", 32'(frame_done), 1);
    repeat (C - HALF - 1) step();
    chk("t4_busy_end", 32'(busy), 0);
    for (int i = 1; i < 5; i++) begin
      chk("t4_pop", 32'(rd_data), 32'(32'h20 + i));
      pop_one();
    end
    chk("t4_drained", 32'(rd_valid), 0);

    // Continuous burst aborted mid-word
    fd_base = fd_cnt;
    begin_burst(8'd0, 1'b0);
    send_word(8'h31, 1'b0, C);
    send_word(8'h32, 1'b0, C);
    miso = 1'b1;
    repeat (4 * C) step();
    chk("t5_busy_cont", 32'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_busy_stop", 32'(busy), 0);
    chk("t5_count_stop", 32'(count), 2);
    chk("t5_head", 32'(rd_data), 32'h31);
    repeat (2 * C) step();
    chk("t5_count_later", 32'(count), 2);
    chk("t5_fdone_pulses", 32'(fd_cnt - fd_base), 2);

    // Reset mid-word discards buffered and partial data
    begin_burst(8'd0, 1'b0);
    send_word(8'h33, 1'b0, C);
    chk("t5_count_pre_rst", 32'(count), 3);
    repeat (5) step();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    chk("t5_rst_count", 32'(count), 0);
    chk("t5_rst_valid", 32'(rd_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_data", 32'(rd_data), 0);
    step();

    // stop wins over a same-cycle word completion
    begin_burst(8'd0, 1'b0);
    send_word(8'h44, 1'b0, HALF);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_prio_count", 32'(count), 0);
    chk("t5_prio_fdone", 32'(frame_done), 0);
    chk("t5_prio_busy", 32'(busy), 0);

`ifdef T05_SERIAL_RX_PARITY_EN
    begin_burst(8'd1, 1'b0);
    send_word(8'h41, 1'b0, C);
    chk("t6_good_count", 32'(count), 1);
    chk("t6_good_data", 32'(rd_data), 32'h41);
    chk("t6_good_perr", 32'(parity_err), 0);
    pop_one();
    begin_burst(8'd1, 1'b0);
    send_word(8'h41, 1'b1, C - 1);
    chk("t6_bad_fdone", 32'(frame_done), 1);
    chk("t6_bad_count", 32'(count), 0);
    chk("t6_bad_valid", 32'(rd_valid), 0);
    chk("t6_bad_perr", 32'(parity_err), 1);
    step();
    chk("t6_bad_busy", 32'(busy), 0);
    chk("t6_perr_sticky", 32'(parity_err), 1);
`else
    chk("t6_perr_tied", 32'(parity_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
